// File: rtl/mem_cache_pkg.sv
// Shared definitions for the MEM-stage cache controller.
// Provides the controller state encoding and helpers that derive the
// address-field widths from the cache geometry.
package mem_cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_e;

  // Byte-offset bits inside one word.
  function automatic int offset_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word-offset bits inside one line (0 when a line is a single word).
  function automatic int word_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int data_w,
                               input int words_per_line, input int sets);
    return addr_w - index_w(sets) - word_w(words_per_line) - offset_w(data_w);
  endfunction

  // Width of a way number; at least one bit so direct-mapped still has a port.
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_plru.sv
// Pseudo-LRU replacement helper for one set.
// Ports:
//   plru_i      current PLRU bits of the set (3 bits, only as many used as WAYS needs)
//   valid_i     valid bit per way of the set
//   touch_i     way being accessed this cycle
//   victim_o    way to fill: lowest invalid way, else the PLRU victim
//   plru_next_o PLRU bits after touching touch_i
module cache_plru
  import mem_cache_pkg::*;
#(
  parameter int WAYS = 2
) (
  input  logic [2:0]             plru_i,
  input  logic [WAYS-1:0]        valid_i,
  input  logic [way_w(WAYS)-1:0] touch_i,
  output logic [way_w(WAYS)-1:0] victim_o,
  output logic [2:0]             plru_next_o
);

  localparam int WAY_W = way_w(WAYS);

  logic [WAY_W-1:0] tree_victim;

  // Bits point at the least recently used side; touching a way points them away.
  if (WAYS == 1) begin : g_dm
    logic unused_plru;
    assign unused_plru = ^{plru_i, touch_i};
    assign tree_victim = '0;
    assign plru_next_o = plru_i;
  end else if (WAYS == 2) begin : g_w2
    assign tree_victim = plru_i[0];
    assign plru_next_o = {plru_i[2:1], ~touch_i[0]};
  end else if (WAYS == 4) begin : g_w4
    // bit0 selects pair {0,1} vs {2,3}; bit1 / bit2 select within each pair.
    assign tree_victim = plru_i[0] ? {1'b1, plru_i[2]} : {1'b0, plru_i[1]};
    always_comb begin
      plru_next_o    = plru_i;
      plru_next_o[0] = ~touch_i[1];
      if (touch_i[1]) plru_next_o[2] = ~touch_i[0];
      else            plru_next_o[1] = ~touch_i[0];
    end
  end else begin : g_bad
    $error("cache_plru: WAYS must be 1, 2 or 4");
  end

  // Empty ways are always filled before anything is evicted.
  always_comb begin
    victim_o = tree_victim;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) victim_o = WAY_W'(w);
    end
  end

endmodule

// File: rtl/mem_cache_ctrl.sv
// Set-associative write-through / no-write-allocate cache between the MEM
// stage and the SRAM controller.
// Ports:
//   clk, rst           clock; synchronous active-low reset
//   rd_en, wr_en       load / store request, held while ready=0
//   address            byte address (word aligned)
//   write_data         store data
//   inv                invalidate all lines (IDLE only)
//   read_data, ready   load data / request complete (0 freezes the pipe)
//   mem_rd_en/mem_wr_en, mem_addr, mem_wdata   backend request
//   mem_rdata, mem_ready                       backend line data / completion pulse
//   hit_cnt, miss_cnt  saturating load hit / miss counters
module mem_cache_ctrl
  import mem_cache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 2,
  parameter int SETS           = 64,
  parameter int WAYS           = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rd_en,
  input  logic                             wr_en,
  input  logic [ADDR_W-1:0]                address,
  input  logic [DATA_W-1:0]                write_data,
  input  logic                             inv,
  output logic [DATA_W-1:0]                read_data,
  output logic                             ready,
  output logic                             mem_rd_en,
  output logic                             mem_wr_en,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W-1:0]                mem_wdata,
  input  logic [WORDS_PER_LINE*DATA_W-1:0] mem_rdata,
  input  logic                             mem_ready,
  output logic [31:0]                      hit_cnt,
  output logic [31:0]                      miss_cnt
);

  localparam int BYTE_W   = offset_w(DATA_W);
  localparam int WO_W     = word_w(WORDS_PER_LINE);
  localparam int WO_BITS  = (WO_W > 0) ? WO_W : 1;
  localparam int IDX_W    = index_w(SETS);
  localparam int TAG_W    = tag_w(ADDR_W, DATA_W, WORDS_PER_LINE, SETS);
  localparam int WAY_W    = way_w(WAYS);
  localparam int LINE_OFF = BYTE_W + WO_W;

  // Storage
  logic [WORDS_PER_LINE*DATA_W-1:0] data_mem [SETS][WAYS];
  logic [TAG_W-1:0]                 tag_mem  [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0]        valid_q;
  logic [SETS-1:0][2:0]             plru_q;

  state_e      state_q, state_d;
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]   tag;
  logic [IDX_W-1:0]   set_idx;
  logic [WO_BITS-1:0] word_idx;
  logic [ADDR_W-1:0]  line_addr;

  assign tag       = TAG_W'(address >> (LINE_OFF + IDX_W));
  assign set_idx   = IDX_W'(address >> LINE_OFF);
  assign word_idx  = (WO_W > 0) ? WO_BITS'(address >> BYTE_W) : '0;
  assign line_addr = (address >> LINE_OFF) << LINE_OFF;

  logic             hit;
  logic [WAY_W-1:0] hit_way, victim, touch_way;
  logic [2:0]       plru_next;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && tag_mem[set_idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  cache_plru #(.WAYS(WAYS)) u_plru (
    .plru_i      (plru_q[set_idx]),
    .valid_i     (valid_q[set_idx]),
    .touch_i     (touch_way),
    .victim_o    (victim),
    .plru_next_o (plru_next)
  );

  logic fill_en, wr_upd_en, plru_upd, inv_en, hit_inc, miss_inc;

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    read_data = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = address;
    fill_en   = 1'b0;
    wr_upd_en = 1'b0;
    plru_upd  = 1'b0;
    touch_way = hit_way;
    inv_en    = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // inv takes priority; a request in the same cycle waits one cycle.
        if (inv) begin
          inv_en = 1'b1;
        end else if (wr_en) begin
          state_d = WR_THRU;
        end else if (rd_en) begin
          if (hit) begin
            ready     = 1'b1;
            read_data = data_mem[set_idx][hit_way][int'(word_idx)*DATA_W +: DATA_W];
            plru_upd  = 1'b1;
            hit_inc   = 1'b1;
          end else begin
            miss_inc = 1'b1;
            state_d  = RD_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end
      RD_MISS: begin
        mem_rd_en = 1'b1;
        mem_addr  = line_addr;
        if (mem_ready) begin
          ready     = 1'b1;
          read_data = mem_rdata[int'(word_idx)*DATA_W +: DATA_W];
          fill_en   = 1'b1;
          plru_upd  = 1'b1;
          touch_way = victim;
          state_d   = IDLE;
        end
      end
      WR_THRU: begin
        mem_wr_en = 1'b1;
        if (mem_ready) begin
          ready     = 1'b1;
          wr_upd_en = hit;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    hit_cnt_d  = (hit_inc  && hit_cnt_q  != 32'hFFFF_FFFF) ? hit_cnt_q  + 32'd1 : hit_cnt_q;
    miss_cnt_d = (miss_inc && miss_cnt_q != 32'hFFFF_FFFF) ? miss_cnt_q + 32'd1 : miss_cnt_q;
  end

  assign mem_wdata = write_data;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
      plru_q     <= '0;
    end else begin
      state_q    <= state_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (inv_en)       valid_q                  <= '0;
      else if (fill_en) valid_q[set_idx][victim] <= 1'b1;
      if (plru_upd)     plru_q[set_idx]          <= plru_next;
    end
  end

  // Line storage is not reset; gating with rst keeps an aborted miss from filling.
  always_ff @(posedge clk) begin
    if (rst && fill_en) begin
      data_mem[set_idx][victim] <= mem_rdata;
      tag_mem[set_idx][victim]  <= tag;
    end
    if (rst && wr_upd_en) begin
      data_mem[set_idx][hit_way][int'(word_idx)*DATA_W +: DATA_W] <= write_data;
    end
  end

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Directed bench for mem_cache_ctrl (WAYS=2, SETS=64, WORDS_PER_LINE=2).
module tb_mem_cache_ctrl;

  localparam logic [1:0] OP_RD = 2'd0, OP_WR = 2'd1, OP_RW = 2'd2;

  logic        clk = 1'b0;
  logic        rst, rd_en, wr_en, inv, mem_ready;
  logic [31:0] address, write_data, read_data, mem_addr, mem_wdata, hit_cnt, miss_cnt;
  logic        ready, mem_rd_en, mem_wr_en;
  logic [63:0] mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] bmem [logic [31:0]];

  mem_cache_ctrl #(.ADDR_W(32), .DATA_W(32), .WORDS_PER_LINE(2), .SETS(64), .WAYS(2)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .inv(inv), .read_data(read_data), .ready(ready),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_hit;
    logic [31:0] exp_rdata;
    int          exp_hits;
    int          exp_misses;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [31:0] bword(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return 32'hC000_0000 | a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One complete access, including the backend handshake for misses and stores.
  task automatic do_access(input string nm, input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic exp_hit,
                           input logic [31:0] exp_rdata, input int eh, input int em);
    logic [31:0] line;
    line = addr & ~32'h7;
    @(negedge clk);
    inv        = 1'b0;
    rd_en      = (op != OP_WR);
    wr_en      = (op != OP_RD);
    address    = addr;
    write_data = wdata;
    #1;
    if (op == OP_RD && exp_hit) begin
      chk({nm, " hit ready"}, 32'(ready), 32'd1);
      chk({nm, " hit data"}, read_data, exp_rdata);
    end else begin
      chk({nm, " idle ready"}, 32'(ready), 32'd0);
      @(negedge clk); #1;
      if (op == OP_RD) begin
        chk({nm, " mem_rd_en"}, 32'(mem_rd_en), 32'd1);
        chk({nm, " mem_addr"}, mem_addr, line);
      end else begin
        chk({nm, " mem_wr_en"}, 32'(mem_wr_en), 32'd1);
        chk({nm, " mem_addr"}, mem_addr, addr);
        chk({nm, " mem_wdata"}, mem_wdata, wdata);
      end
      chk({nm, " wait ready"}, 32'(ready), 32'd0);
      if (op == OP_RD) repeat (2) @(negedge clk);
      else @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = {bword(line + 32'd4), bword(line)};
      #1;
      chk({nm, " done ready"}, 32'(ready), 32'd1);
      if (op == OP_RD) chk({nm, " fill data"}, read_data, exp_rdata);
      if (op == OP_RW) chk({nm, " rw data"}, read_data, 32'd0);
      if (op != OP_RD) bmem[addr] = wdata;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = '0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    #1;
    chk({nm, " mem_en idle"}, 32'({mem_rd_en, mem_wr_en}), 32'd0);
    chk({nm, " hit_cnt"}, hit_cnt, 32'(eh));
    chk({nm, " miss_cnt"}, miss_cnt, 32'(em));
  endtask

  initial begin
    // A=0x000, B=0x200, C=0x400, 0x800 all map to set 0; 0x100 maps to set 32.
    vecs[0]  = '{OP_RD, 32'h100, 32'h0,    1'b0, 32'hC000_0100, 0, 1};
    vecs[1]  = '{OP_RD, 32'h104, 32'h0,    1'b1, 32'hC000_0104, 1, 1};
    vecs[2]  = '{OP_WR, 32'h104, 32'hDEAD, 1'b1, 32'h0,         1, 1};
    vecs[3]  = '{OP_RD, 32'h104, 32'h0,    1'b1, 32'h0000_DEAD, 2, 1};
    vecs[4]  = '{OP_RD, 32'h000, 32'h0,    1'b0, 32'hC000_0000, 2, 2};
    vecs[5]  = '{OP_RD, 32'h200, 32'h0,    1'b0, 32'hC000_0200, 2, 3};
    vecs[6]  = '{OP_RD, 32'h000, 32'h0,    1'b1, 32'hC000_0000, 3, 3};
    vecs[7]  = '{OP_RD, 32'h400, 32'h0,    1'b0, 32'hC000_0400, 3, 4};
    vecs[8]  = '{OP_RD, 32'h004, 32'h0,    1'b1, 32'hC000_0004, 4, 4};
    vecs[9]  = '{OP_RD, 32'h200, 32'h0,    1'b0, 32'hC000_0200, 4, 5};
    vecs[10] = '{OP_RD, 32'h404, 32'h0,    1'b0, 32'hC000_0404, 4, 6};
    vecs[11] = '{OP_WR, 32'h800, 32'h1234, 1'b0, 32'h0,         4, 6};
    vecs[12] = '{OP_RD, 32'h800, 32'h0,    1'b0, 32'h0000_1234, 4, 7};
    vecs[13] = '{OP_RD, 32'h100, 32'h0,    1'b1, 32'hC000_0100, 5, 7};
    vecs[14] = '{OP_RW, 32'h104, 32'hBEEF, 1'b1, 32'h0,         5, 7};
    vecs[15] = '{OP_RD, 32'h104, 32'h0,    1'b1, 32'h0000_BEEF, 6, 7};

    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; inv = 1'b0; mem_ready = 1'b0;
    address = '0; write_data = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset mem_en", 32'({mem_rd_en, mem_wr_en}), 32'd0);
    chk("reset hit_cnt", hit_cnt, 32'd0);
    chk("reset miss_cnt", miss_cnt, 32'd0);

    for (int i = 0; i < 16; i++) begin
      do_access($sformatf("v%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_hit, vecs[i].exp_rdata, vecs[i].exp_hits, vecs[i].exp_misses);
    end

    // Invalidate with a load in the same cycle: inv wins, load then misses.
    @(negedge clk);
    inv = 1'b1; rd_en = 1'b1; address = 32'h100;
    #1;
    chk("inv ready", 32'(ready), 32'd0);
    chk("inv mem_rd_en", 32'(mem_rd_en), 32'd0);
    do_access("inv rd 100", OP_RD, 32'h100, 32'h0, 1'b0, 32'hC000_0100, 6, 8);
    do_access("inv rd 800", OP_RD, 32'h800, 32'h0, 1'b0, 32'h0000_1234, 6, 9);

    // Reset in the middle of a miss, then a stray mem_ready in IDLE.
    @(negedge clk);
    rd_en = 1'b1; address = 32'h300;
    @(negedge clk); #1;
    chk("abort mem_rd_en before", 32'(mem_rd_en), 32'd1);
    @(negedge clk);
    rst = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort mem_rd_en after", 32'(mem_rd_en), 32'd0);
    chk("abort ready", 32'(ready), 32'd1);
    chk("abort miss_cnt", miss_cnt, 32'd0);
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = {bword(32'h304), bword(32'h300)};
    #1;
    chk("stray mem_en", 32'({mem_rd_en, mem_wr_en}), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
    chk("stray ready", 32'(ready), 32'd1);
    do_access("post rst rd 300", OP_RD, 32'h300, 32'h0, 1'b0, 32'hC000_0300, 0, 1);
    do_access("post rst rd 100", OP_RD, 32'h100, 32'h0, 1'b0, 32'hC000_0100, 0, 2);
    do_access("post rst rd 304", OP_RD, 32'h304, 32'h0, 1'b1, 32'hC000_0304, 1, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
